pwm_apb_regs: RTL and testbench

APB slave register block that sits directly upstream of the 3-channel PWM core and drives its `enable_i`, `prescaler_i`, `pwm_period_i` and `duty_cycle_i` inputs. Software writes staging registers and then requests a commit. The block applies the staged values to the core atomically, either at a PWM period boundary or immediately when all channels are disabled. It also provides a sticky period-done status with an interrupt output.

---
 rtl/pwm_apb_regs.sv | 144 ++++++++++++++
 tb/tb_pwm_apb_regs.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_apb_regs.sv
// APB register block feeding the 3-channel PWM core: staging registers with an
// atomic commit on a period boundary (or immediately when idle), plus sticky status/irq.
module pwm_apb_regs #(
  parameter int NCH = 3,
  parameter int AW  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           psel,
  input  logic           penable,
  input  logic           pwrite,
  input  logic [AW-1:0]  paddr,
  input  logic [31:0]    pwdata,
  output logic [31:0]    prdata,
  output logic           pready,
  output logic           pslverr,
  input  logic           period_end_i,
  output logic [NCH-1:0] enable_o,
  output logic [31:0]    prescaler_o,
  output logic [31:0]    pwm_period_o,
  output logic [31:0]    duty_cycle_o,
  output logic           irq_o
);

  localparam logic [2:0] IDX_CTRL   = 3'd0;
  localparam logic [2:0] IDX_PRESC  = 3'd1;
  localparam logic [2:0] IDX_PERIOD = 3'd2;
  localparam logic [2:0] IDX_DUTY   = 3'd3;
  localparam logic [2:0] IDX_STATUS = 3'd4;
  localparam logic [2:0] IDX_UPDATE = 3'd5;

  logic [NCH-1:0] stg_enable;
  logic           irq_en;
  logic [31:0]    stg_presc;
  logic [31:0]    stg_period;
  logic [31:0]    stg_duty;
  logic           period_done;
  logic           update_pending;

  logic [2:0]     reg_idx;
  logic           addr_ok;
  logic           wr_en;
  logic           rd_setup;
  logic           commit;
  logic [31:0]    clamped_duty;
  logic [31:0]    rdata;
  logic           unused_addr_bits;

  // APB: setup phase is psel & ~penable, access phase is psel & penable; pready
  // is tied high so every transfer is exactly two cycles. Writes take effect on
  // the access edge; read data and pslverr are captured on the setup edge and
  // held through the access phase.
  assign pready           = 1'b1;
  assign reg_idx          = paddr[4:2];
  assign addr_ok          = (paddr[AW-1:5] == '0) && (reg_idx <= IDX_UPDATE);
  assign wr_en            = psel & penable & pwrite & addr_ok;
  assign rd_setup         = psel & ~penable;
  assign unused_addr_bits = ^paddr[1:0];

  // Commit uses the register values before any same-edge write lands.
  assign commit       = update_pending & (period_end_i | (enable_o == '0));
  assign clamped_duty = (stg_duty > stg_period) ? stg_period : stg_duty;

  always_comb begin
    rdata = '0;
    case (reg_idx)
      IDX_CTRL: begin
        rdata[NCH-1:0] = stg_enable;
        rdata[8]       = irq_en;
      end
      IDX_PRESC:  rdata = stg_presc;
      IDX_PERIOD: rdata = stg_period;
      IDX_DUTY:   rdata = stg_duty;
      IDX_STATUS: rdata[1:0] = {update_pending, period_done};
      default:    rdata = '0;
    endcase
    if (!addr_ok) rdata = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_enable <= '0;
      irq_en     <= 1'b0;
      stg_presc  <= '0;
      stg_period <= '0;
      stg_duty   <= '0;
    end else if (wr_en) begin
      case (reg_idx)
        IDX_CTRL: begin
          stg_enable <= pwdata[NCH-1:0];
          irq_en     <= pwdata[8];
        end
        IDX_PRESC:  stg_presc  <= pwdata;
        IDX_PERIOD: stg_period <= pwdata;
        IDX_DUTY:   stg_duty   <= pwdata;
        default: ;
      endcase
    end
  end

  // An UPDATE write always leaves pending set, even on a commit edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      update_pending <= 1'b0;
      enable_o       <= '0;
      prescaler_o    <= '0;
      pwm_period_o   <= '0;
      duty_cycle_o   <= '0;
    end else begin
      if (wr_en && reg_idx == IDX_UPDATE) update_pending <= 1'b1;
      else if (commit)                    update_pending <= 1'b0;
      if (commit) begin
        enable_o     <= stg_enable;
        prescaler_o  <= stg_presc;
        pwm_period_o <= stg_period;
        duty_cycle_o <= clamped_duty;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_done <= 1'b0;
      irq_o       <= 1'b0;
    end else begin
      if (period_end_i)
        period_done <= 1'b1;
      else if (wr_en && reg_idx == IDX_STATUS && pwdata[0])
        period_done <= 1'b0;
      irq_o <= period_done & irq_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prdata  <= '0;
      pslverr <= 1'b0;
    end else if (rd_setup) begin
      prdata  <= pwrite ? 32'h0 : rdata;
      pslverr <= ~addr_ok;
    end
  end

endmodule

// File: tb/tb_pwm_apb_regs.sv
// Self-checking bench for pwm_apb_regs: APB driver tasks, read scoreboard,
// commit timing, duty clamp, irq latency and mid-transfer reset.
module tb_pwm_apb_regs;

  localparam int NCH = 3;
  localparam int AW  = 8;

  logic           clk;
  logic           rst;
  logic           psel;
  logic           penable;
  logic           pwrite;
  logic [AW-1:0]  paddr;
  logic [31:0]    pwdata;
  logic [31:0]    prdata;
  logic           pready;
  logic           pslverr;
  logic           period_end_i;
  logic [NCH-1:0] enable_o;
  logic [31:0]    prescaler_o;
  logic [31:0]    pwm_period_o;
  logic [31:0]    duty_cycle_o;
  logic           irq_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];

  pwm_apb_regs #(.NCH(NCH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .period_end_i(period_end_i), .enable_o(enable_o),
    .prescaler_o(prescaler_o), .pwm_period_o(pwm_period_o),
    .duty_cycle_o(duty_cycle_o), .irq_o(irq_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: each starts and ends 1ns after a rising edge
  task automatic apb_write(input logic [AW-1:0] addr, input logic [31:0] data);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input string tag, input logic [AW-1:0] addr,
                          input logic [31:0] exp_data, input logic exp_err);
    logic [32:0] exp;
    exp_q.push_back({exp_err, exp_data});
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
    @(posedge clk); #1;
    penable = 1'b1;
    check({tag, "_pready"}, 64'(pready), 64'd1);
    exp = exp_q.pop_front();
    check(tag, 64'({pslverr, prdata}), 64'(exp));
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic pulse_period_end();
    period_end_i = 1'b1;
    @(posedge clk); #1;
    period_end_i = 1'b0;
  endtask

  // write whose access edge coincides with a period_end_i pulse
  task automatic apb_write_with_period_end(input logic [AW-1:0] addr, input logic [31:0] data);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
    @(posedge clk); #1;
    penable = 1'b1; period_end_i = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; period_end_i = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input logic [NCH-1:0] en,
                               input logic [31:0] ps, input logic [31:0] per,
                               input logic [31:0] dut_duty);
    check({tag, "_en"},     64'(enable_o),     64'(en));
    check({tag, "_presc"},  64'(prescaler_o),  64'(ps));
    check({tag, "_period"}, 64'(pwm_period_o), 64'(per));
    check({tag, "_duty"},   64'(duty_cycle_o), 64'(dut_duty));
  endtask

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; period_end_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    check_outputs("rst", '0, 0, 0, 0);
    check("rst_irq", 64'(irq_o), 64'd0);
    check("rst_prdata", 64'(prdata), 64'd0);
    check("rst_pslverr", 64'(pslverr), 64'd0);
    for (int i = 0; i < 6; i++) apb_read("rst_rd", AW'(i * 4), 32'h0, 1'b0);
    apb_read("unmapped_18", 8'h18, 32'h0, 1'b1);
    apb_read("unmapped_1c", 8'h1C, 32'h0, 1'b1);
    apb_read("unmapped_40", 8'h40, 32'h0, 1'b1);
    apb_write(8'h44, 32'h1234);
    apb_read("unmapped_wr_presc", 8'h04, 32'h0, 1'b0);

    // idle commit: outputs move on the edge after the UPDATE access edge
    apb_write(8'h04, 32'd4);
    apb_write(8'h08, 32'd100);
    apb_write(8'h0C, 32'd30);
    apb_write(8'h00, 32'h7);
    apb_read("rd_presc", 8'h04, 32'd4, 1'b0);
    apb_read("rd_ctrl", 8'h00, 32'h7, 1'b0);
    apb_write(8'h14, 32'h0);
    check_outputs("idle_before", '0, 0, 0, 0);
    @(posedge clk); #1;
    check_outputs("idle_commit", 3'h7, 4, 100, 30);
    apb_read("idle_status", 8'h10, 32'h0, 1'b0);
    apb_read("rd_update", 8'h14, 32'h0, 1'b0);

    // enabled: commit waits for period_end_i
    apb_write(8'h0C, 32'd60);
    apb_write(8'h14, 32'h1);
    repeat (20) @(posedge clk);
    #1;
    check("wait_duty", 64'(duty_cycle_o), 64'd30);
    apb_read("wait_status", 8'h10, 32'h2, 1'b0);
    pulse_period_end();
    check("pe_duty", 64'(duty_cycle_o), 64'd60);
    apb_read("pe_status", 8'h10, 32'h1, 1'b0);

    // clamp duty to period
    apb_write(8'h08, 32'd50);
    apb_write(8'h0C, 32'd80);
    apb_write(8'h14, 32'h1);
    pulse_period_end();
    check_outputs("clamp", 3'h7, 4, 50, 50);

    // staging write on the commit edge: commit sees the old staged duty
    apb_write(8'h0C, 32'd20);
    apb_write(8'h14, 32'h1);
    apb_write_with_period_end(8'h0C, 32'd40);
    check("same_cycle_duty", 64'(duty_cycle_o), 64'd20);
    apb_read("same_cycle_stg", 8'h0C, 32'd40, 1'b0);
    apb_read("same_cycle_status", 8'h10, 32'h1, 1'b0);

    // W1C, then irq latency
    apb_write(8'h10, 32'h1);
    apb_write(8'h00, 32'h107);
    apb_read("irq_ctrl", 8'h00, 32'h107, 1'b0);
    check("irq_idle", 64'(irq_o), 64'd0);
    pulse_period_end();
    check("irq_edge1", 64'(irq_o), 64'd0);
    @(posedge clk); #1;
    check("irq_edge2", 64'(irq_o), 64'd1);
    apb_write_with_period_end(8'h10, 32'h1);
    check("irq_set_wins", 64'(irq_o), 64'd1);
    apb_read("set_wins_status", 8'h10, 32'h1, 1'b0);
    apb_write(8'h10, 32'h1);
    check("irq_w1c_edge0", 64'(irq_o), 64'd1);
    @(posedge clk); #1;
    check("irq_w1c_edge1", 64'(irq_o), 64'd0);
    apb_read("w1c_status", 8'h10, 32'h0, 1'b0);

    // reset mid-transfer with an update pending
    apb_write(8'h08, 32'd77);
    apb_write(8'h14, 32'h1);
    apb_read("pre_rst_status", 8'h10, 32'h2, 1'b0);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h08;
    @(posedge clk); #1;
    rst = 1'b1; penable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    check_outputs("mid_rst", '0, 0, 0, 0);
    check("mid_rst_irq", 64'(irq_o), 64'd0);
    check("mid_rst_prdata", 64'(prdata), 64'd0);
    check("mid_rst_pslverr", 64'(pslverr), 64'd0);
    apb_read("mid_rst_status", 8'h10, 32'h0, 1'b0);
    apb_read("mid_rst_period", 8'h08, 32'h0, 1'b0);
    pulse_period_end();
    @(posedge clk); #1;
    check_outputs("post_rst_pe", '0, 0, 0, 0);
    apb_read("post_rst_status", 8'h10, 32'h1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
